fu_pipe: RTL

- Parametrised, pipelined successor to the combinational F1 function unit.
- Operations: signed abs, min, max, add/sub with selectable first operand, and variable logical/arithmetic shifts.
- Supplies a signed-overflow flag and a reserved-opcode error flag.
- Two-stage pipeline with valid/ready handshakes on both sides; sits between the FPU issue logic and writeback, so it tolerates writeback back-pressure.

---
 rtl/fu_pkg.sv | 19 +
 rtl/fu_alu.sv | 71 +++++++
 rtl/fu_pipe.sv | 110 +++++++++++
 3 files changed

// File: rtl/fu_pkg.sv
// fu_pkg: shared constants for the pipelined function unit.
//   OP_W        opcode width
//   OP_ABS..    opcode encodings; values 10..15 are reserved
package fu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_ABS  = 4'd0;
  localparam logic [OP_W-1:0] OP_MIN  = 4'd1;
  localparam logic [OP_W-1:0] OP_MAX  = 4'd2;
  localparam logic [OP_W-1:0] OP_ADD  = 4'd3;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd4;
  localparam logic [OP_W-1:0] OP_ADDC = 4'd5;
  localparam logic [OP_W-1:0] OP_SUBC = 4'd6;
  localparam logic [OP_W-1:0] OP_SHL  = 4'd7;
  localparam logic [OP_W-1:0] OP_SHR  = 4'd8;
  localparam logic [OP_W-1:0] OP_SRA  = 4'd9;

endpackage

// File: rtl/fu_alu.sv
// fu_alu: purely combinational datapath of the function unit.
//   op    opcode (fu_pkg encodings)
//   in0   operand A, in1 operand B, in2 operand C / shift amount source
//   data  result (0 for reserved opcodes)
//   ovf   signed overflow for ABS/ADD/SUB/ADDC/SUBC
//   err   reserved opcode
module fu_alu
  import fu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] data,
  output logic             ovf,
  output logic             err
);

  localparam int SH_W = $clog2(WIDTH);

  logic [SH_W-1:0]  amt_s;
  logic             use_c_s;
  logic             sub_s;
  logic [WIDTH-1:0] a_s;
  logic [WIDTH-1:0] b_s;
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] neg_s;
  logic             sum_ovf_s;
  logic             lt_s;

  // Shared adder: subtraction is a + ~b + 1, so one overflow rule covers all four add/sub ops.
  always_comb begin
    amt_s     = in2[SH_W-1:0];
    use_c_s   = (op == OP_ADDC) || (op == OP_SUBC);
    sub_s     = (op == OP_SUB)  || (op == OP_SUBC);
    a_s       = use_c_s ? in2 : in0;
    b_s       = sub_s ? ~in1 : in1;
    sum_s     = a_s + b_s + {{(WIDTH-1){1'b0}}, sub_s};
    // Overflow: addends share a sign and the sum's sign differs from it.
    sum_ovf_s = (a_s[WIDTH-1] == b_s[WIDTH-1]) && (sum_s[WIDTH-1] != a_s[WIDTH-1]);
    neg_s     = {WIDTH{1'b0}} - in0;
    lt_s      = $signed(in0) < $signed(in1);
  end

  // Result select per opcode; reserved opcodes produce zero with err set.
  always_comb begin
    data = {WIDTH{1'b0}};
    ovf  = 1'b0;
    err  = 1'b0;
    case (op)
      OP_ABS: begin
        data = in0[WIDTH-1] ? neg_s : in0;
        // Only the most negative value stays negative after negation.
        ovf  = in0[WIDTH-1] & neg_s[WIDTH-1];
      end
      OP_MIN:  data = lt_s ? in0 : in1;
      OP_MAX:  data = lt_s ? in1 : in0;
      OP_ADD, OP_SUB, OP_ADDC, OP_SUBC: begin
        data = sum_s;
        ovf  = sum_ovf_s;
      end
      OP_SHL:  data = in1 << amt_s;
      OP_SHR:  data = in1 >> amt_s;
      OP_SRA:  data = $unsigned($signed(in1) >>> amt_s);
      default: err  = 1'b1;
    endcase
  end

endmodule

// File: rtl/fu_pipe.sv
// fu_pipe: two-stage pipelined function unit with valid/ready on both sides.
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         input handshake; in_op, in_tag, in0..in2 payload
//   out_valid/out_ready       output handshake; out_data, out_tag, out_ovf, out_err payload
// S1 holds the accepted operation, S2 holds the computed result. No skid buffer:
// in_ready is combinational from out_ready.
module fu_pipe
  import fu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_ovf,
  output logic             out_err
);

  logic             s1_v_r;
  logic [OP_W-1:0]  s1_op_r;
  logic [TAG_W-1:0] s1_tag_r;
  logic [WIDTH-1:0] s1_in0_r;
  logic [WIDTH-1:0] s1_in1_r;
  logic [WIDTH-1:0] s1_in2_r;

  logic             s2_v_r;
  logic [WIDTH-1:0] s2_data_r;
  logic [TAG_W-1:0] s2_tag_r;
  logic             s2_ovf_r;
  logic             s2_err_r;

  logic             s1_adv_s;
  logic             s2_adv_s;
  logic [WIDTH-1:0] alu_data_s;
  logic             alu_ovf_s;
  logic             alu_err_s;

  fu_alu #(.WIDTH(WIDTH)) u_alu (
    .op   (s1_op_r),
    .in0  (s1_in0_r),
    .in1  (s1_in1_r),
    .in2  (s1_in2_r),
    .data (alu_data_s),
    .ovf  (alu_ovf_s),
    .err  (alu_err_s)
  );

  // Stage advance: a stage may load when it is empty or its occupant moves on.
  always_comb begin
    s2_adv_s = !s2_v_r || out_ready;
    s1_adv_s = !s1_v_r || s2_adv_s;
  end

  // Pipeline registers for both stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_r    <= 1'b0;
      s1_op_r   <= {OP_W{1'b0}};
      s1_tag_r  <= {TAG_W{1'b0}};
      s1_in0_r  <= {WIDTH{1'b0}};
      s1_in1_r  <= {WIDTH{1'b0}};
      s1_in2_r  <= {WIDTH{1'b0}};
      s2_v_r    <= 1'b0;
      s2_data_r <= {WIDTH{1'b0}};
      s2_tag_r  <= {TAG_W{1'b0}};
      s2_ovf_r  <= 1'b0;
      s2_err_r  <= 1'b0;
    end else begin
      if (s1_adv_s) begin
        s1_v_r <= in_valid;
        // Payload only moves with a real operation to avoid needless toggling.
        if (in_valid) begin
          s1_op_r  <= in_op;
          s1_tag_r <= in_tag;
          s1_in0_r <= in0;
          s1_in1_r <= in1;
          s1_in2_r <= in2;
        end
      end
      if (s2_adv_s) begin
        s2_v_r <= s1_v_r;
        if (s1_v_r) begin
          s2_data_r <= alu_data_s;
          s2_tag_r  <= s1_tag_r;
          s2_ovf_r  <= alu_ovf_s;
          s2_err_r  <= alu_err_s;
        end
      end
    end
  end

  assign in_ready  = s1_adv_s;
  assign out_valid = s2_v_r;
  assign out_data  = s2_data_r;
  assign out_tag   = s2_tag_r;
  assign out_ovf   = s2_ovf_r;
  assign out_err   = s2_err_r;

endmodule
